mc_control_unit: RTL and testbench

//  Multicycle ARM control unit, directly upstream of the conditional logic stage. It decodes
//  op/funct/rd of the latched instruction and steps a Moore FSM (FETCH..WB) per instruction.
//  Its unconditional pcs/regw/memw/flagw feed conditional logic; its mux selects and ALU

---
 rtl/mc_ctrl_pkg.sv | 72 +++++++
 rtl/mc_main_fsm.sv | 142 ++++++++++++++
 rtl/mc_control_unit.sv | 102 ++++++++++
 tb/tb_mc_control_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared types and encodings for the multicycle ARM control unit:
//   state_t    - main FSM states, FETCH through BRANCH
//   OP_*       - instr[27:26] instruction classes
//   CMD_*      - instr[24:21] data-processing commands
//   ALU_*      - alucontrol encodings driven onto the datapath ALU
//   SRCB_*     - alusrcb mux selects
//   RES_*      - resultsrc mux selects
//   decode_cmd - maps a DP command to ALU control plus properties
// ----------------------------------------------------------------------------
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECUTER,
        EXECUTEI,
        ALUWB,
        BRANCH
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_B   = 2'b10;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_CMP = 4'b1010;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // supported: command is in the implemented subset
    // arith:     command produces meaningful C/V flags (add, sub, cmp)
    typedef struct packed {
        logic [1:0] ctrl;
        logic       supported;
        logic       arith;
    } alu_dec_t;

    function automatic alu_dec_t decode_cmd(input logic [3:0] cmd);
        alu_dec_t d;
        d = '{ctrl: ALU_ADD, supported: 1'b0, arith: 1'b0};
        case (cmd)
            CMD_ADD: d = '{ctrl: ALU_ADD, supported: 1'b1, arith: 1'b1};
            CMD_SUB: d = '{ctrl: ALU_SUB, supported: 1'b1, arith: 1'b1};
            CMD_CMP: d = '{ctrl: ALU_SUB, supported: 1'b1, arith: 1'b1};
            CMD_AND: d = '{ctrl: ALU_AND, supported: 1'b1, arith: 1'b0};
            CMD_ORR: d = '{ctrl: ALU_ORR, supported: 1'b1, arith: 1'b0};
            default: d = '{ctrl: ALU_ADD, supported: 1'b0, arith: 1'b0};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mc_main_fsm.sv
// ----------------------------------------------------------------------------
// mc_main_fsm
// Main Moore FSM of the multicycle control unit: state register, next-state
// logic and the per-state datapath controls.
// Ports:
//   clk, reset   - rising-edge clock, synchronous active-high reset
//   op           - instruction class (instr[27:26])
//   imm          - funct[5], immediate operand for DP
//   load         - funct[0], load/store for memory instructions
//   irwrite      - instruction register enable (FETCH)
//   nextpc       - unconditional PC <= PC+4 (FETCH)
//   adrsrc       - memory address select (1 = ALU result)
//   alusrca      - ALU A select (1 = PC)
//   alusrcb      - ALU B select
//   resultsrc    - result bus select
//   memw         - memory write request (MEMWRITE)
//   mem_wb       - in MEMWB, load writeback
//   alu_wb       - in ALUWB, DP writeback
//   branch       - in BRANCH
//   aluop        - ALU control comes from the DP command (EXECUTE states)
//   in_decode    - in DECODE
// All outputs are forced to 0 while reset is high.
// ----------------------------------------------------------------------------
module mc_main_fsm
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] op,
    input  logic       imm,
    input  logic       load,
    output logic       irwrite,
    output logic       nextpc,
    output logic       adrsrc,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] resultsrc,
    output logic       memw,
    output logic       mem_wb,
    output logic       alu_wb,
    output logic       branch,
    output logic       aluop,
    output logic       in_decode
);

    state_t state;
    state_t state_next;

    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values; combinational blocks below use blocking.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned, which would infer a latch.
        state_next = FETCH;
        case (state)
            FETCH:    state_next = DECODE;
            DECODE: begin
                case (op)
                    OP_MEM:  state_next = MEMADR;
                    OP_DP:   state_next = imm ? EXECUTEI : EXECUTER;
                    OP_B:    state_next = BRANCH;
                    default: state_next = FETCH;   // illegal class aborts
                endcase
            end
            MEMADR:   state_next = load ? MEMREAD : MEMWRITE;
            MEMREAD:  state_next = MEMWB;
            EXECUTER: state_next = ALUWB;
            EXECUTEI: state_next = ALUWB;
            MEMWB,
            MEMWRITE,
            ALUWB,
            BRANCH:   state_next = FETCH;
            default:  state_next = FETCH;
        endcase
    end

    // Moore outputs; reset overrides whatever state the register holds so
    // a mid-instruction reset never leaks a write enable.
    always_comb begin
        irwrite   = 1'b0;
        nextpc    = 1'b0;
        adrsrc    = 1'b0;
        alusrca   = 1'b0;
        alusrcb   = SRCB_RD2;
        resultsrc = RES_ALUOUT;
        memw      = 1'b0;
        mem_wb    = 1'b0;
        alu_wb    = 1'b0;
        branch    = 1'b0;
        aluop     = 1'b0;
        in_decode = 1'b0;
        if (!reset) begin
            case (state)
                FETCH: begin
                    alusrca   = 1'b1;
                    alusrcb   = SRCB_FOUR;
                    resultsrc = RES_ALURESULT;
                    irwrite   = 1'b1;
                    nextpc    = 1'b1;
                end
                DECODE: begin
                    // PC+8 precompute for R15 reads
                    alusrca   = 1'b1;
                    alusrcb   = SRCB_FOUR;
                    resultsrc = RES_ALURESULT;
                    in_decode = 1'b1;
                end
                MEMADR:   alusrcb = SRCB_IMM;
                MEMREAD:  adrsrc  = 1'b1;
                MEMWB: begin
                    resultsrc = RES_DATA;
                    mem_wb    = 1'b1;
                end
                MEMWRITE: begin
                    adrsrc = 1'b1;
                    memw   = 1'b1;
                end
                EXECUTER: aluop = 1'b1;
                EXECUTEI: begin
                    alusrcb = SRCB_IMM;
                    aluop   = 1'b1;
                end
                ALUWB:    alu_wb = 1'b1;
                BRANCH: begin
                    alusrcb   = SRCB_IMM;
                    resultsrc = RES_ALURESULT;
                    branch    = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mc_control_unit.sv
// ----------------------------------------------------------------------------
// mc_control_unit
// Multicycle ARM control unit (DP ADD/SUB/AND/ORR/CMP, LDR/STR, B). Steps the
// main FSM per instruction and derives ALU control, flag/register/PC write
// requests and the illegal-instruction pulse from the latched IR fields.
// Ports:
//   clk, reset  - rising-edge clock, synchronous active-high reset
//   op          - instr[27:26]
//   funct       - instr[25:20]: [5]=I, [4:1]=cmd, [0]=S (mem: L)
//   rd          - instr[15:12]
//   pcs, regw, memw, flagw - unconditional write requests to cond. logic
//   irwrite, nextpc        - IR enable, PC <= PC+4
//   adrsrc, alusrca, alusrcb, resultsrc - datapath mux selects
//   alucontrol  - ALU operation
//   immsrc      - extend-unit select (= op)
//   regsrc      - register-file read-address selects
//   illegal     - one-cycle pulse in DECODE for unsupported instructions
// ----------------------------------------------------------------------------
module mc_control_unit
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [3:0] rd,
    output logic       pcs,
    output logic       regw,
    output logic       memw,
    output logic [1:0] flagw,
    output logic       irwrite,
    output logic       nextpc,
    output logic       adrsrc,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] resultsrc,
    output logic [1:0] alucontrol,
    output logic [1:0] immsrc,
    output logic [1:0] regsrc,
    output logic       illegal
);

    logic     mem_wb;
    logic     alu_wb;
    logic     branch;
    logic     aluop;
    logic     in_decode;
    logic     is_cmp;
    logic     set_flags;
    alu_dec_t dec;

    mc_main_fsm u_fsm (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .imm       (funct[5]),
        .load      (funct[0]),
        .irwrite   (irwrite),
        .nextpc    (nextpc),
        .adrsrc    (adrsrc),
        .alusrca   (alusrca),
        .alusrcb   (alusrcb),
        .resultsrc (resultsrc),
        .memw      (memw),
        .mem_wb    (mem_wb),
        .alu_wb    (alu_wb),
        .branch    (branch),
        .aluop     (aluop),
        .in_decode (in_decode)
    );

    assign dec       = decode_cmd(funct[4:1]);
    assign is_cmp    = (funct[4:1] == CMD_CMP);
    assign set_flags = funct[0];

    // Outside the EXECUTE states the ALU only forms addresses and PC sums.
    assign alucontrol = aluop ? dec.ctrl : ALU_ADD;

    // CMP exists only to set flags, so it writes all of them even without S.
    always_comb begin
        flagw = 2'b00;
        if (aluop) begin
            if (is_cmp) begin
                flagw = 2'b11;
            end else begin
                flagw = {set_flags, set_flags & dec.arith};
            end
        end
    end

    assign regw = mem_wb | (alu_wb & ~is_cmp);

    // A register write to R15 is a jump.
    assign pcs = branch | (regw & (rd == 4'hF));

    assign illegal = in_decode & ((op == 2'b11) | ((op == OP_DP) & ~dec.supported));

    // IR-field driven selects are held at 0 during reset like everything else.
    assign immsrc = reset ? 2'b00 : op;
    assign regsrc = reset ? 2'b00 : {op == OP_MEM, op == OP_B};

endmodule

// File: tb/tb_mc_control_unit.sv
// ----------------------------------------------------------------------------
// tb_mc_control_unit
// Self-checking bench for mc_control_unit. An instruction-level model turns
// each (op, funct, rd) into the list of per-cycle output bundles it must
// produce; a single compare process checks the DUT against that list at
// every falling edge. Stimulus is directed cases followed by random
// instructions with occasional mid-instruction resets.
// ----------------------------------------------------------------------------
module tb_mc_control_unit;

    typedef struct packed {
        logic       pcs;
        logic       regw;
        logic       memw;
        logic [1:0] flagw;
        logic       irwrite;
        logic       nextpc;
        logic       adrsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] resultsrc;
        logic [1:0] alucontrol;
        logic [1:0] immsrc;
        logic [1:0] regsrc;
        logic       illegal;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       pcs, regw, memw, irwrite, nextpc, adrsrc, alusrca, illegal;
    logic [1:0] flagw, alusrcb, resultsrc, alucontrol, immsrc, regsrc;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];
    exp_t model_q[$];
    exp_t cur;
    logic [3:0] good_cmds [5] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};

    mc_control_unit dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .rd         (rd),
        .pcs        (pcs),
        .regw       (regw),
        .memw       (memw),
        .flagw      (flagw),
        .irwrite    (irwrite),
        .nextpc     (nextpc),
        .adrsrc     (adrsrc),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .resultsrc  (resultsrc),
        .alucontrol (alucontrol),
        .immsrc     (immsrc),
        .regsrc     (regsrc),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    // Instruction-level model: each instruction is fetch, decode, then the
    // class-specific tail cycles with their documented controls.
    task automatic build(input logic [1:0] o, input logic [5:0] f, input logic [3:0] r);
        exp_t       base;
        exp_t       e;
        logic [3:0] cmd;
        logic       s;
        logic       rd15;
        logic [1:0] alu;
        logic       ok;
        logic       arith;
        logic       cmp;
        cmd  = f[4:1];
        s    = f[0];
        rd15 = (r == 4'd15);
        cmp  = (cmd == 4'b1010);
        alu = 2'b00; ok = 1'b0; arith = 1'b0;
        case (cmd)
            4'b0100: begin alu = 2'b00; ok = 1'b1; arith = 1'b1; end
            4'b0010: begin alu = 2'b01; ok = 1'b1; arith = 1'b1; end
            4'b1010: begin alu = 2'b01; ok = 1'b1; arith = 1'b1; end
            4'b0000: begin alu = 2'b10; ok = 1'b1; end
            4'b1100: begin alu = 2'b11; ok = 1'b1; end
            default: ;
        endcase
        model_q.delete();
        base        = '0;
        base.immsrc = o;
        base.regsrc = {o == 2'b01, o == 2'b10};
        // fetch: PC+4 into PC, latch IR
        e = base; e.alusrca = 1; e.alusrcb = 2; e.resultsrc = 2; e.irwrite = 1; e.nextpc = 1;
        model_q.push_back(e);
        // decode: PC+8
        e = base; e.alusrca = 1; e.alusrcb = 2; e.resultsrc = 2;
        e.illegal = (o == 2'b11) || (o == 2'b00 && !ok);
        model_q.push_back(e);
        case (o)
            2'b01: begin
                e = base; e.alusrcb = 1; model_q.push_back(e);
                if (f[0]) begin
                    e = base; e.adrsrc = 1; model_q.push_back(e);
                    e = base; e.resultsrc = 1; e.regw = 1; e.pcs = rd15; model_q.push_back(e);
                end else begin
                    e = base; e.adrsrc = 1; e.memw = 1; model_q.push_back(e);
                end
            end
            2'b00: begin
                e = base;
                e.alusrcb    = f[5] ? 2'd1 : 2'd0;
                e.alucontrol = alu;
                e.flagw      = cmp ? 2'b11 : {s, s & arith};
                model_q.push_back(e);
                e = base; e.regw = !cmp; e.pcs = rd15 && !cmp; model_q.push_back(e);
            end
            2'b10: begin
                e = base; e.alusrcb = 1; e.resultsrc = 2; e.pcs = 1; model_q.push_back(e);
            end
            default: ;
        endcase
    endtask

    // Single compare process: one expected bundle per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            check("pcs",        32'(pcs),        32'(cur.pcs));
            check("regw",       32'(regw),       32'(cur.regw));
            check("memw",       32'(memw),       32'(cur.memw));
            check("flagw",      32'(flagw),      32'(cur.flagw));
            check("irwrite",    32'(irwrite),    32'(cur.irwrite));
            check("nextpc",     32'(nextpc),     32'(cur.nextpc));
            check("adrsrc",     32'(adrsrc),     32'(cur.adrsrc));
            check("alusrca",    32'(alusrca),    32'(cur.alusrca));
            check("alusrcb",    32'(alusrcb),    32'(cur.alusrcb));
            check("resultsrc",  32'(resultsrc),  32'(cur.resultsrc));
            check("alucontrol", 32'(alucontrol), 32'(cur.alucontrol));
            check("immsrc",     32'(immsrc),     32'(cur.immsrc));
            check("regsrc",     32'(regsrc),     32'(cur.regsrc));
            check("illegal",    32'(illegal),    32'(cur.illegal));
        end
    end

    // Called at posedge+1 at the start of a FETCH cycle. Runs `cut` cycles of
    // the instruction (all of it when rst_cycles==0), then optionally holds
    // reset for rst_cycles cycles, during which every output must be 0.
    task automatic run_instr(input logic [1:0] o, input logic [5:0] f, input logic [3:0] r,
                             input int cut, input int rst_cycles);
        int n;
        op = o; funct = f; rd = r;
        build(o, f, r);
        n = model_q.size();
        if (rst_cycles > 0 && cut < n) n = cut;
        for (int i = 0; i < n; i++) exp_q.push_back(model_q[i]);
        repeat (n) @(posedge clk);
        #1;
        if (rst_cycles > 0) begin
            reset = 1'b1;
            for (int i = 0; i < rst_cycles; i++) exp_q.push_back('0);
            repeat (rst_cycles) @(posedge clk);
            #1;
            reset = 1'b0;
        end
    endtask

    initial begin
        logic [1:0] o;
        logic [5:0] f;
        logic [3:0] r;
        int         sel;
        int         cut;
        int         rc;

        reset = 1'b1; op = 2'b00; funct = 6'd0; rd = 4'd0;

        // Hand-computed pins on the model itself.
        build(2'b01, 6'b011001, 4'd1);
        check("model_ldr_len", model_q.size(), 5);
        check("model_ldr_memwb_regw", 32'(model_q[4].regw), 1);
        check("model_ldr_memread_adrsrc", 32'(model_q[3].adrsrc), 1);
        build(2'b01, 6'b011000, 4'd2);
        check("model_str_len", model_q.size(), 4);
        check("model_str_memw", 32'(model_q[3].memw), 1);
        build(2'b00, 6'b000101, 4'd15);
        check("model_subs_alu", 32'(model_q[2].alucontrol), 1);
        check("model_subs_flagw", 32'(model_q[2].flagw), 3);
        check("model_subs_pcs", 32'(model_q[3].pcs), 1);
        build(2'b00, 6'b110101, 4'd3);
        check("model_cmp_flagw", 32'(model_q[2].flagw), 3);
        check("model_cmp_regw", 32'(model_q[3].regw), 0);
        build(2'b10, 6'b000000, 4'd0);
        check("model_b_len", model_q.size(), 3);
        check("model_b_pcs", 32'(model_q[2].pcs), 1);
        build(2'b11, 6'b000000, 4'd0);
        check("model_ill_len", model_q.size(), 2);
        check("model_ill_pulse", 32'(model_q[1].illegal), 1);

        // Power-on reset: outputs all 0 while held.
        @(posedge clk); #1;
        exp_q.push_back('0); exp_q.push_back('0);
        repeat (2) @(posedge clk); #1;
        reset = 1'b0;

        // Directed instructions.
        run_instr(2'b01, 6'b011001, 4'd1,  0, 0);   // LDR r1
        run_instr(2'b01, 6'b011000, 4'd2,  0, 0);   // STR
        run_instr(2'b00, 6'b000101, 4'd15, 0, 0);   // SUBS r15, reg
        run_instr(2'b00, 6'b110101, 4'd3,  0, 0);   // CMP imm
        run_instr(2'b10, 6'b101010, 4'd0,  0, 0);   // B
        run_instr(2'b11, 6'b010101, 4'd5,  0, 0);   // illegal class
        run_instr(2'b00, 6'b001101, 4'd4,  0, 0);   // unsupported cmd 0110
        run_instr(2'b01, 6'b011001, 4'd15, 0, 0);   // LDR pc
        run_instr(2'b01, 6'b011001, 4'd1,  3, 2);   // reset held 2 cycles in MEMREAD
        run_instr(2'b00, 6'b101001, 4'd7,  0, 0);   // ADDS imm after reset

        // Random instruction stream with occasional mid-instruction resets.
        for (int k = 0; k < 300; k++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 3)      o = 2'b00;
            else if (sel <= 6) o = 2'b01;
            else if (sel <= 8) o = 2'b10;
            else               o = 2'b11;
            f = 6'($urandom);
            if (o == 2'b00 && $urandom_range(0, 3) != 0) f[4:1] = good_cmds[$urandom_range(0, 4)];
            r = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
            cut = 0; rc = 0;
            if ($urandom_range(0, 11) == 0) begin
                cut = $urandom_range(1, 4);
                rc  = $urandom_range(1, 2);
            end
            run_instr(o, f, r, cut, rc);
        end

        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
